// File: rtl/freq_peak_detect.sv
`default_nettype none
// ============================================================================
//  Module   : freq_peak_detect
//  Purpose  : Scans a 16-bin complex FFT frame (Q8.8 re/im) one bin per
//             cycle and reports the index and squared magnitude of the
//             strongest bin. Ties resolve to the lowest index.
//  Revision : 1.0 - initial release
// ============================================================================
module freq_peak_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  input  logic        fft_valid,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] mag_max,
  output logic        drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_IDX = 4'd15;

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [3:0]  r_idx;
  logic        [31:0] r_buf [16];
  logic        [31:0] r_best_mag;
  logic        [3:0]  r_best_idx;
  logic        [3:0]  r_freq;
  logic        [31:0] r_mag_max;
  logic               r_drop;

  logic        [31:0] w_din [16];
  logic               w_capture;
  logic        [31:0] w_bin;
  logic signed [15:0] w_re;
  logic signed [15:0] w_im;
  logic signed [31:0] w_re_sq;
  logic signed [31:0] w_im_sq;
  logic        [31:0] w_mag;
  logic               w_take;
  logic        [31:0] w_best_mag_nxt;
  logic        [3:0]  w_best_idx_nxt;

  assign w_din[0]  = fft_d0;
  assign w_din[1]  = fft_d1;
  assign w_din[2]  = fft_d2;
  assign w_din[3]  = fft_d3;
  assign w_din[4]  = fft_d4;
  assign w_din[5]  = fft_d5;
  assign w_din[6]  = fft_d6;
  assign w_din[7]  = fft_d7;
  assign w_din[8]  = fft_d8;
  assign w_din[9]  = fft_d9;
  assign w_din[10] = fft_d10;
  assign w_din[11] = fft_d11;
  assign w_din[12] = fft_d12;
  assign w_din[13] = fft_d13;
  assign w_din[14] = fft_d14;
  assign w_din[15] = fft_d15;

  // Squared magnitude of the bin currently addressed by the scan index.
  // Signed squares are never negative and the largest, (-2^15)^2 = 2^30,
  // fits a signed 32-bit product, so the unsigned sum cannot overflow.
  assign w_bin   = r_buf[r_idx];
  assign w_re    = w_bin[31:16];
  assign w_im    = w_bin[15:0];
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;
  assign w_mag   = unsigned'(w_re_sq) + unsigned'(w_im_sq);

  // Bin 0 seeds the running best; later bins must be strictly larger so
  // that equal magnitudes keep the lower index.
  assign w_take         = (r_idx == 4'd0) || (w_mag > r_best_mag);
  assign w_best_mag_nxt = w_take ? w_mag : r_best_mag;
  assign w_best_idx_nxt = w_take ? r_idx : r_best_idx;

  // Next-state logic and Moore outputs; a new frame is accepted whenever
  // the scanner is not busy, including the DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fft_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (fft_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, scan index, running best and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_best_mag <= 32'd0;
      r_best_idx <= 4'd0;
      r_freq     <= 4'd0;
      r_mag_max  <= 32'd0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= fft_valid && (r_state == S_SCAN);
      if (w_capture) begin
        r_idx <= 4'd0;
      end else if (r_state == S_SCAN) begin
        r_idx      <= r_idx + 4'd1;
        r_best_mag <= w_best_mag_nxt;
        r_best_idx <= w_best_idx_nxt;
        if (r_idx == c_LAST_IDX) begin
          r_freq    <= w_best_idx_nxt;
          r_mag_max <= w_best_mag_nxt;
        end
      end
    end
  end

  // Frame buffer; contents are irrelevant until a capture fills them.
  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      for (int k = 0; k < 16; k++) begin
        r_buf[k] <= w_din[k];
      end
    end
  end

  assign freq    = r_freq;
  assign mag_max = r_mag_max;
  assign drop    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_freq_peak_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_peak_detect
//  Purpose  : Scoreboard bench for freq_peak_detect. Expected results are
//             queued with their due cycle when a frame is driven and are
//             checked when that cycle arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_peak_detect;

  typedef struct {
    int          due;
    logic [3:0]  freq;
    logic [31:0] mag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] mag_max;
  logic        drop;

  exp_t        q[$];
  int          cyc = 0;
  int          drop_due = -1;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  exp_freq = 4'd0;
  logic [31:0] exp_mag = 32'd0;

  freq_peak_detect u_dut (
    .clk      (clk),
    .rst      (rst),
    .fft_d0   (d[0]),
    .fft_d1   (d[1]),
    .fft_d2   (d[2]),
    .fft_d3   (d[3]),
    .fft_d4   (d[4]),
    .fft_d5   (d[5]),
    .fft_d6   (d[6]),
    .fft_d7   (d[7]),
    .fft_d8   (d[8]),
    .fft_d9   (d[9]),
    .fft_d10  (d[10]),
    .fft_d11  (d[11]),
    .fft_d12  (d[12]),
    .fft_d13  (d[13]),
    .fft_d14  (d[14]),
    .fft_d15  (d[15]),
    .fft_valid(fft_valid),
    .done     (done),
    .freq     (freq),
    .mag_max  (mag_max),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference peak search over the frame currently on d[].
  task automatic model(output logic [3:0] f, output logic [31:0] m);
    logic signed [15:0] re, im;
    longint             mag;
    f = 4'd0;
    m = 32'd0;
    for (int k = 0; k < 16; k++) begin
      re  = d[k][31:16];
      im  = d[k][15:0];
      mag = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (k == 0 || mag > longint'(m)) begin
        f = 4'(k);
        m = 32'(mag);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 16; k++) d[k] = 32'd0;
  endtask

  // Drives the frame on d[] for one cycle; the bench decides from its own
  // pending-frame record whether the DUT is busy and expects drop if so.
  task automatic send();
    exp_t e;
    fft_valid = 1'b1;
    if (q.size() == 0 || cyc >= q[$].due) begin
      e.due = cyc + 17;
      model(e.freq, e.mag);
      q.push_back(e);
    end else begin
      drop_due = cyc + 1;
    end
    idle(1);
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = $urandom;
  endtask

  task automatic do_reset(input bit with_valid);
    rst       = 1'b1;
    fft_valid = with_valid;
    idle(1);
    rst       = 1'b0;
    fft_valid = 1'b0;
    q.delete();
    drop_due = -1;
    exp_freq = 4'd0;
    exp_mag  = 32'd0;
  endtask

  // Per-cycle monitor: done/drop timing and held result values.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        exp_freq = q[0].freq;
        exp_mag  = q[0].mag;
        void'(q.pop_front());
      end else begin
        check_eq("done_idle", {31'd0, done}, 32'd0);
      end
      check_eq("drop", {31'd0, drop}, {31'd0, (drop_due == cyc)});
      check_eq("freq", {28'd0, freq}, {28'd0, exp_freq});
      check_eq("mag_max", mag_max, exp_mag);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_frame();
    idle(3);
    do_reset(1'b0);
    mon_en = 1'b1;
    idle(2);

    // Single strong bin 5: 0x300^2 + 0x400^2 = 0x190000.
    clear_frame();
    d[5] = 32'h0300_0400;
    send();
    idle(20);

    // Equal bins 3 and 9: lowest index wins.
    clear_frame();
    d[3] = 32'h0100_0100;
    d[9] = 32'h0100_0100;
    send();
    idle(20);

    // Most negative real part beats all 0x7FFF neighbours.
    for (int k = 0; k < 16; k++) d[k] = 32'h7FFF_0000;
    d[12] = 32'h8000_0000;
    send();
    idle(20);

    // All-zero frame reports bin 0 with zero magnitude.
    clear_frame();
    send();
    idle(20);

    // Second frame mid-scan is dropped; first frame result unaffected.
    clear_frame();
    d[7] = 32'hFF00_0200;
    send();
    idle(4);
    clear_frame();
    d[2] = 32'h7FFF_7FFF;
    send();
    idle(20);

    // Back-to-back random frames, each launched in the previous DONE cycle.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 16; k++) begin
        d[k] = (n < 3) ? {8'd0, 8'($urandom_range(0, 3)), 8'd0, 8'($urandom_range(0, 3))}
                       : $urandom;
      end
      send();
      idle(16);
    end
    idle(10);

    // Reset aborts a scan in progress; outputs return to zero.
    clear_frame();
    d[4] = 32'h0200_0000;
    send();
    idle(16);
    clear_frame();
    d[6] = 32'h0500_0000;
    send();
    idle(7);
    do_reset(1'b0);
    idle(25);

    // Reset and valid together: no capture.
    d[1] = 32'h0400_0000;
    do_reset(1'b1);
    idle(25);

    // First valid after reset is accepted.
    clear_frame();
    d[15] = 32'h0000_8000;
    send();
    idle(20);

    check_eq("queue_empty", q.size(), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_peak_detect.md
FREQ_PEAK_DETECT -- requirements
Module: freq_peak_detect

Interface
REQ-001 The block SHALL have no parameters: bin count fixed at 16, sample format fixed at Q8.8.
REQ-002 Port clk SHALL be an input, 1 bit wide: rising-edge clock for all state.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, synchronous, active-high.
REQ-004 Ports fft_d0..fft_d15 SHALL be inputs, 32 bits each: bin k as {re[31:16], im[15:0]}, each part signed Q8.8 two's complement.
REQ-005 Port fft_valid SHALL be an input, 1 bit wide: single-cycle strobe marking all 16 bins valid in that cycle.
REQ-006 Port done SHALL be an output, 1 bit wide: one-cycle pulse when a peak result is ready.
REQ-007 Port freq SHALL be an output, 4 bits wide: index of the peak bin, valid from done and held until the next done.
REQ-008 Port mag_max SHALL be an output, 32 bits wide, unsigned: re^2 + im^2 of the peak bin, held like freq.
REQ-009 Port drop SHALL be an output, 1 bit wide: one-cycle pulse flagging a frame rejected while busy.

Function
REQ-010 The block SHALL implement three FSM states: IDLE, SCAN and DONE.
REQ-011 In IDLE or DONE, fft_valid=1 SHALL capture all 16 input words into an internal buffer at that clock edge, clear idx to 0 and enter SCAN.
REQ-012 SCAN SHALL process one bin per cycle, idx 0..15 in order, for exactly 16 cycles.
REQ-013 Each processed bin's magnitude SHALL be mag = re*re + im*im, computed as signed 16x16 products into 32-bit unsigned values, with no truncation or saturation. The maximum is 2*2^30 = 2^31, which fits in 32 bits.
REQ-014 At idx 0, best_mag and best_idx SHALL load unconditionally from bin 0.
REQ-015 At idx 1..15, best_mag and best_idx SHALL update only if mag > best_mag (strictly greater), so ties resolve to the lowest index.
REQ-016 After idx 15 is processed, the FSM SHALL enter DONE, with freq and mag_max registered from the final best_idx/best_mag in the same edge.
REQ-017 done SHALL be high only during the DONE cycle, i.e. exactly 17 cycles after the cycle in which fft_valid was sampled high. The DONE cycle is one cycle long.
REQ-018 DONE SHALL go to IDLE the next cycle, unless fft_valid=1 in that cycle, in which case REQ-011 applies (back-to-back frames, no bubble).
REQ-019 A frame with fft_valid=1 in SCAN SHALL be discarded, leaving the buffer and scan unaffected, and drop SHALL be high in the following cycle for one cycle.
REQ-020 freq and mag_max SHALL change only on the edge that enters DONE and otherwise hold their values.
REQ-021 fft_d* SHALL be ignored whenever fft_valid=0.
REQ-022 The buffer SHALL be read only during SCAN, and the inputs SHALL not need to be held after the fft_valid cycle.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, idx=0, done=0, drop=0, freq=4'd0, mag_max=32'd0, best_mag=0 and best_idx=0. Buffer contents are don't-care.
REQ-024 rst asserted mid-SCAN SHALL abort the frame, producing no done for it.
REQ-025 rst has priority over fft_valid in the same cycle, so no capture occurs in that cycle.
REQ-026 After rst deasserts, the block SHALL accept a frame on the first fft_valid.

Verification
REQ-027 A bench SHALL drive fft_d5=32'h0300_0400 with all other bins 0 and pulse fft_valid at cycle T -> done=1 at T+17, freq=5, mag_max=32'h0019_0000.
REQ-028 A bench SHALL drive fft_d3 = fft_d9 = 32'h0100_0100 with all other bins 0 -> freq=3, mag_max=32'h0002_0000 (tie to lowest index).
REQ-029 A bench SHALL drive fft_d12=32'h8000_0000 with all other bins 32'h7FFF_0000 -> freq=12, mag_max=32'h4000_0000.
REQ-030 A bench SHALL drive an all-zero frame -> done at T+17, freq=0, mag_max=0.
REQ-031 A bench SHALL pulse fft_valid at T and T+5 -> drop=1 at T+6 only, exactly one done at T+17 with the results of the T frame.
REQ-032 A bench SHALL pulse fft_valid at T, then again at T+17 with new data, then assert rst at T+25 -> first done at T+17, no second done, all outputs 0 after the reset edge.
